// File: rtl/rail_tick_pkg.sv
// ============================================================================
// Module      : rail_tick_pkg
// Description : Shared constants and divisor helper for the rail tick
//               generator (channel limits, counter width, reset divisor).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rail_tick_pkg;

  localparam int CNT_W     = 26;
  localparam int DEF_DIV   = 4166667;  // 24 Hz TICK from a 100 MHz clock
  localparam int MAX_CH    = 8;
  localparam int LOAD_CH_W = 3;

  // A divisor of zero has no meaningful period; it behaves as a divisor of 1.
  // Operates on 32 bits so that any counter width up to 32 can share it.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rail_tick_if.sv
// ============================================================================
// Module      : rail_tick_if
// Description : Control/status bundle of the rail tick generator: per-channel
//               enables, sync and divisor-load strobes, TICK/SQ/PEND outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rail_tick_if
  import rail_tick_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = rail_tick_pkg::CNT_W
);

  logic [NUM_CH-1:0]    en;
  logic                 sync;
  logic                 load;
  logic [LOAD_CH_W-1:0] load_ch;
  logic [CNT_W-1:0]     load_div;
  logic [NUM_CH-1:0]    tick;
  logic [NUM_CH-1:0]    sq;
  logic [NUM_CH-1:0]    pend;

  // Controller side: drives enables/strobes, observes the channel outputs.
  modport master (
    output en, sync, load, load_ch, load_div,
    input  tick, sq, pend
  );

  // Generator side.
  modport slave (
    input  en, sync, load, load_ch, load_div,
    output tick, sq, pend
  );

endinterface

`default_nettype wire

// File: rtl/rail_tick_chan.sv
// ============================================================================
// Module      : rail_tick_chan
// Description : One clock-enable channel: down-counter with programmable
//               divisor, deferred (pending) divisor updates, registered
//               one-cycle TICK and 50% duty SQ.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rail_tick_chan
  import rail_tick_pkg::*;
#(
  parameter int CNT_W   = rail_tick_pkg::CNT_W,   // at most 32
  parameter int DEF_DIV = rail_tick_pkg::DEF_DIV
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             en,
  input  wire logic             sync,
  input  wire logic             ld,
  input  wire logic [CNT_W-1:0] ld_div,
  output logic                  tick,
  output logic                  sq,
  output logic                  pend
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(clamp_div(32'(DEF_DIV)));

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] ld_clamped;
  logic [CNT_W-1:0] next_div;

  // Divisor used at a reload point: a same-cycle load beats a pending one,
  // which beats the currently active divisor.
  always_comb begin
    ld_clamped = CNT_W'(clamp_div(32'(ld_div)));
    next_div   = div;
    if (ld) begin
      next_div = ld_clamped;
    end else if (pend) begin
      next_div = pend_div;
    end
  end

  // Counter, divisor, pending slot and output flops; reset > sync > load > count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= RST_DIV - CNT_W'(1);
      div      <= RST_DIV;
      pend_div <= RST_DIV;
      pend     <= 1'b0;
      tick     <= 1'b0;
      sq       <= 1'b0;
    end else if (sync) begin
      div  <= next_div;
      cnt  <= next_div - CNT_W'(1);
      pend <= 1'b0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else if (!en) begin
      // Frozen channel: a load cannot truncate a running period, so it
      // takes effect at once.
      tick <= 1'b0;
      if (ld) begin
        div  <= ld_clamped;
        cnt  <= ld_clamped - CNT_W'(1);
        pend <= 1'b0;
      end
    end else if (cnt == '0) begin
      div  <= next_div;
      cnt  <= next_div - CNT_W'(1);
      pend <= 1'b0;
      tick <= 1'b1;
      sq   <= ~sq;
    end else begin
      cnt  <= cnt - CNT_W'(1);
      tick <= 1'b0;
      if (ld) begin
        pend_div <= ld_clamped;
        pend     <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rail_tick_gen.sv
// ============================================================================
// Module      : rail_tick_gen
// Description : Multi-channel clock-enable generator. Decodes the divisor
//               load target and instantiates one rail_tick_chan per channel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rail_tick_gen
  import rail_tick_pkg::*;
#(
  parameter int NUM_CH  = 2,                        // 1..MAX_CH
  parameter int CNT_W   = rail_tick_pkg::CNT_W,
  parameter int DEF_DIV = rail_tick_pkg::DEF_DIV
) (
  input  wire logic  clk,
  input  wire logic  reset,
  rail_tick_if.slave bus
);

  logic [NUM_CH-1:0] ld;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] pend;

  // Target indices >= NUM_CH match no channel, so such loads are dropped.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ld[i] = bus.load && (bus.load_ch == LOAD_CH_W'(i));

      rail_tick_chan #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
      ) u_chan (
        .clk    (clk),
        .reset  (reset),
        .en     (bus.en[i]),
        .sync   (bus.sync),
        .ld     (ld[i]),
        .ld_div (bus.load_div),
        .tick   (tick[i]),
        .sq     (sq[i]),
        .pend   (pend[i])
      );
    end
  endgenerate

  assign bus.tick = tick;
  assign bus.sq   = sq;
  assign bus.pend = pend;

endmodule

`default_nettype wire

// File: tb/tb_rail_tick_gen.sv
// ============================================================================
// Module      : tb_rail_tick_gen
// Description : Self-checking bench for rail_tick_gen (NUM_CH=2, DEF_DIV=4):
//               directed scenarios followed by random traffic, compared each
//               cycle against a cycles-until-tick reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rail_tick_gen;

  localparam int NCH  = 2;
  localparam int CW   = 26;
  localparam int DDIV = 4;

  logic clk = 1'b0;
  logic reset;

  rail_tick_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

  rail_tick_gen #(.NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(DDIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: per channel, how many more rising edges until the next
  // TICK is produced, plus the active and awaiting divisors.
  int unsigned m_left [NCH];
  int unsigned m_div  [NCH];
  int unsigned m_wait [NCH];
  bit          m_has_wait [NCH];
  bit          m_sq   [NCH];
  bit          m_tick [NCH];

  int n_pass  = 0;
  int n_total = 0;

  function automatic int unsigned eff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    for (int i = 0; i < NCH; i++) begin
      bit          hit;
      int unsigned nd;
      hit = bus.load && (int'(bus.load_ch) == i);
      if (hit)                nd = eff(int'(bus.load_div));
      else if (m_has_wait[i]) nd = m_wait[i];
      else                    nd = m_div[i];
      if (reset) begin
        m_left[i] = DDIV; m_div[i] = DDIV; m_has_wait[i] = 0;
        m_sq[i] = 0; m_tick[i] = 0;
      end else if (bus.sync) begin
        m_div[i] = nd; m_left[i] = nd; m_has_wait[i] = 0;
        m_sq[i] = 0; m_tick[i] = 0;
      end else if (!bus.en[i]) begin
        m_tick[i] = 0;
        if (hit) begin
          m_div[i] = nd; m_left[i] = nd; m_has_wait[i] = 0;
        end
      end else if (m_left[i] == 1) begin
        m_div[i] = nd; m_left[i] = nd; m_has_wait[i] = 0;
        m_tick[i] = 1; m_sq[i] = !m_sq[i];
      end else begin
        m_left[i] = m_left[i] - 1;
        m_tick[i] = 0;
        if (hit) begin
          m_wait[i] = nd; m_has_wait[i] = 1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NCH-1:0] e_tick, e_sq, e_pend;
    for (int i = 0; i < NCH; i++) begin
      e_tick[i] = m_tick[i];
      e_sq[i]   = m_sq[i];
      e_pend[i] = m_has_wait[i];
    end
    n_total++;
    assert (bus.tick === e_tick) n_pass++;
    else $error("FAIL %s tick observed=%b expected=%b t=%0t", tag, bus.tick, e_tick, $time);
    n_total++;
    assert (bus.sq === e_sq) n_pass++;
    else $error("FAIL %s sq observed=%b expected=%b t=%0t", tag, bus.sq, e_sq, $time);
    n_total++;
    assert (bus.pend === e_pend) n_pass++;
    else $error("FAIL %s pend observed=%b expected=%b t=%0t", tag, bus.pend, e_pend, $time);
  endtask

  // One clock: inputs held since the last falling edge, check at falling edge.
  task automatic cyc(input string tag, input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
    end
  endtask

  task automatic do_load(input string tag, input int ch, input int unsigned d);
    bus.load = 1'b1; bus.load_ch = 3'(ch); bus.load_div = CW'(d);
    cyc(tag);
    bus.load = 1'b0;
  endtask

  task automatic do_reset(input string tag, input int n);
    reset = 1'b1;
    cyc(tag, n);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; bus.en = '0; bus.sync = 1'b0; bus.load = 1'b0;
    bus.load_ch = '0; bus.load_div = '0;
    for (int i = 0; i < NCH; i++) begin
      m_left[i] = 0; m_div[i] = 0; m_wait[i] = 0; m_has_wait[i] = 0;
      m_sq[i] = 0; m_tick[i] = 0;
    end
    @(negedge clk);

    // Reset state and default-divisor ticking.
    do_reset("reset", 2);
    bus.en = 2'b11;
    cyc("default_div", 14);

    // Deferred load on channel 0, applied at its terminal count.
    do_reset("reset2", 1);
    cyc("pre_load", 2);
    do_load("load_ch0_d6", 0, 6);
    cyc("after_load_d6", 14);

    // Two loads back to back: only the last one is applied.
    do_load("load_ch1_d3", 1, 3);
    do_load("load_ch1_d5", 1, 5);
    cyc("after_overwrite", 15);

    // Out-of-range channel index changes nothing.
    do_load("load_ch5", 5, 2);
    cyc("after_bad_ch", 3);

    // Freeze channel 0, resume, then load while frozen.
    bus.en = 2'b10;
    cyc("frozen", 10);
    bus.en = 2'b11;
    cyc("resumed", 6);
    bus.en = 2'b10;
    do_load("load_frozen_d2", 0, 2);
    cyc("frozen2", 2);
    bus.en = 2'b11;
    cyc("resumed2", 6);

    // Phase alignment via SYNC, including a same-cycle load.
    bus.en = 2'b00;
    do_load("set_ch0_d3", 0, 3);
    do_load("set_ch1_d5", 1, 5);
    bus.en = 2'b11;
    cyc("pre_sync", 2);
    bus.sync = 1'b1;
    cyc("sync");
    bus.sync = 1'b0;
    cyc("after_sync", 12);
    bus.sync = 1'b1; bus.load = 1'b1; bus.load_ch = 3'd0; bus.load_div = CW'(4);
    cyc("sync_with_load");
    bus.sync = 1'b0; bus.load = 1'b0;
    cyc("after_sync_load", 9);

    // Zero divisor, then reset with a pending load.
    do_load("load_d0", 0, 0);
    cyc("div_one", 6);
    do_load("pending_before_reset", 1, 9);
    do_reset("mid_reset", 1);
    cyc("after_mid_reset", 9);

    // Random traffic.
    for (int r = 0; r < 400; r++) begin
      bus.en       = (($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1);
      bus.load     = ($urandom_range(0, 5) == 0);
      bus.load_ch  = 3'($urandom_range(0, 2));
      bus.load_div = CW'($urandom_range(0, 7));
      bus.sync     = ($urandom_range(0, 29) == 0);
      reset        = ($urandom_range(0, 149) == 0);
      cyc("random");
    end
    reset = 1'b0; bus.load = 1'b0; bus.sync = 1'b0;
    cyc("random_tail", 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
